rsram_bank_sched: RTL and testbench
===================================

Name: rsram_bank_sched

Overview:
- Schedules the three line banks of the read SRAM between the pixel loader (writer) and the CNN window address generator (reader).
- Hands free banks to the loader in rotation and tracks each bank as FREE, FILL or FULL.
- Starts the address generator once the selected bank pair is FULL, then recycles banks on each bank_ok.
- Sits between the frame DMA/loader and the rsram address generator, which receives genaddr_start and the bank-pair select from this block.

Parameters:
- PIC_W, 8, width of pic_size, the line count per frame.
- PERF_W, 16, width of the optional stall counter.

Ports:
- SYS_CLK  in  1  system clock
- SYS_RST  in  1  asynchronous active-low reset
- frame_start  in  1  pulse; begin a frame
- pic_size  in  PIC_W  lines (banks to fill) per frame
- wr_req  in  1  loader requests a bank
- wr_grant  out  1  one-cycle grant pulse
- wr_bank  out  2  bank granted (0..2), valid with wr_grant and held until wr_done
- wr_done  in  1  pulse; granted bank is filled
- genaddr_start  out  1  one-cycle pulse to the address generator
- rd_banksel  out  2  pair select: 00 = banks 0/1, 01 = banks 1/2, 10 = banks 2/0; held during RUN
- bank_ok  in  1  pulse; reader finished the current pair
- frame_done  out  1  one-cycle pulse
- busy  out  1  high from the cycle after frame_start until frame_done
- err_proto  out  1  sticky protocol error, cleared only by reset
- perf_stall_cnt  out  PERF_W  optional, see Optional Feature

Behaviour:
- Reset: the following are cleared asynchronously:
  - all outputs to 0;
  - every bank to FREE;
  - wr_ptr, rd_ptr, wr_cnt, pair_cnt to 0;
  - the FSM to IDLE.
- Effective line count is N = max(pic_size, 2). Pairs consumed per frame is N-1.
- Writer side:
  - wr_grant fires when wr_req=1, no fill is outstanding, bank[wr_ptr] is FREE, busy=1 and wr_cnt<N.
  - On grant: bank[wr_ptr] becomes FILL and wr_bank=wr_ptr.
  - On wr_done: the filled bank becomes FULL, wr_ptr advances 0→1→2→0 and wr_cnt increments.
- Reader FSM states: IDLE, WAIT, RUN, DONE.
  - IDLE: on frame_start, latch N and go to WAIT.
  - WAIT: when bank[rd_ptr] and bank[(rd_ptr+1)%3] are both FULL, drive rd_banksel=rd_ptr, pulse genaddr_start on the same cycle the FSM enters RUN, then go to RUN. Condition to pulse latency is 1 cycle.
  - RUN: on bank_ok, set bank[rd_ptr] to FREE, advance rd_ptr mod 3 and increment pair_cnt.
    - If pair_cnt == N-2 (last pair), also free bank[(rd_ptr+1)%3] and go to DONE.
    - Otherwise go to WAIT.
  - DONE: pulse frame_done, clear the pointers and counters, go to IDLE.
- Bank state updates take effect on the next cycle. A bank freed by bank_ok in cycle t can be granted at t+1, never at t.
- wr_done and bank_ok in the same cycle: both are applied, and they always target different banks.
- Errors (all set err_proto):
  - frame_start while busy: ignored.
  - bank_ok outside RUN.
  - wr_done with no fill outstanding.
  - wr_req ignored when not busy: no error.
- Reset mid-frame aborts immediately. Outstanding fills are dropped and no frame_done is issued.

Optional Feature:
- Macro: RSRAM_SCHED_PERF_EN.
- Defined: perf_stall_cnt counts cycles spent in WAIT.
  - Cleared on frame_start.
  - Saturates at all-ones.
- Undefined: no counter logic; perf_stall_cnt is tied to 0.

Decomposition:
- Package rsram_pkg holds:
  - bank state encodings: FREE=2'b00, FILL=2'b01, FULL=2'b10;
  - reader FSM one-hot state localparams;
  - pair-select encodings;
  - NUM_BANK=3.
- Sub-module rsram_bank_tracker holds the three bank-state registers and the set/clear ports. It exports is_free[2:0] and is_full[2:0].

Test Plan:
- Nominal: pic_size=4, loader responds 3 cycles after each grant. Expect grants to banks 0,1,2,0; genaddr_start ×3 with rd_banksel 00,01,10; then frame_done; err_proto=0.
- Back-pressure: pic_size=8, reader holds bank_ok 20 cycles. Expect no grant while all three banks are FILL/FULL; the grant to bank 0 comes 1 cycle after the first bank_ok frees it.
- Same-cycle wr_done and bank_ok. Expect both applied: one bank becomes FULL and the other FREE the next cycle.
- Errors: frame_start during busy, and bank_ok in IDLE. Expect err_proto=1 and the current frame to complete unaffected.
- pic_size=0. Expect treatment as N=2: 2 grants, 1 genaddr_start with rd_banksel=00, then frame_done.
- Reset asserted mid-RUN. Expect all outputs 0 asynchronously; a following frame_start runs normally from bank 0.

Source files
------------

// File: rtl/rsram_pkg.sv
// Shared encodings for the read-SRAM bank scheduler: bank states,
// one-hot reader FSM states, pair-select codes and bank-index helpers.
package rsram_pkg;

   localparam int NUM_BANK = 3;

   // per-bank occupancy
   typedef enum logic [1:0] {
      BANK_FREE = 2'b00,
      BANK_FILL = 2'b01,
      BANK_FULL = 2'b10
   } bank_st_e;

   // reader FSM, one-hot
   localparam logic [3:0] ST_IDLE = 4'b0001;
   localparam logic [3:0] ST_WAIT = 4'b0010;
   localparam logic [3:0] ST_RUN  = 4'b0100;
   localparam logic [3:0] ST_DONE = 4'b1000;

   typedef enum logic [3:0] {
      IDLE = ST_IDLE,
      WAIT = ST_WAIT,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } rd_state_e;

   // bank pair seen by the address generator
   localparam logic [1:0] PAIR_01 = 2'b00;
   localparam logic [1:0] PAIR_12 = 2'b01;
   localparam logic [1:0] PAIR_20 = 2'b10;

   // next bank in the 0->1->2->0 rotation
   function automatic logic [1:0] bank_inc(input logic [1:0] b);
      return (b == 2'd2) ? 2'd0 : b + 2'd1;
   endfunction

   // pair select for a pair starting at bank p
   function automatic logic [1:0] pair_sel(input logic [1:0] p);
      case (p)
         2'd0:    return PAIR_01;
         2'd1:    return PAIR_12;
         default: return PAIR_20;
      endcase
   endfunction

endpackage

// File: rtl/rsram_bank_tracker.sv
// Holds the FREE/FILL/FULL state of each line bank. Free has priority,
// but the scheduler never targets one bank with two updates in a cycle.
module rsram_bank_tracker
   import rsram_pkg::*;
(
   input  logic                SYS_CLK,
   input  logic                SYS_RST,
   input  logic                fill_en,
   input  logic [1:0]          fill_idx,
   input  logic                full_en,
   input  logic [1:0]          full_idx,
   input  logic [NUM_BANK-1:0] free_mask,
   output logic [NUM_BANK-1:0] is_free,
   output logic [NUM_BANK-1:0] is_full
);

   for (genvar i = 0; i < NUM_BANK; i++) begin : g_bank
      localparam logic [1:0] IDX = 2'(i);
      bank_st_e st;

      // one bank's state register
      always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
         if (!SYS_RST)                        st <= BANK_FREE;
         else if (free_mask[i])               st <= BANK_FREE;
         else if (full_en && full_idx == IDX) st <= BANK_FULL;
         else if (fill_en && fill_idx == IDX) st <= BANK_FILL;
      end

      assign is_free[i] = (st == BANK_FREE);
      assign is_full[i] = (st == BANK_FULL);
   end

endmodule

// File: rtl/rsram_bank_sched.sv
// Read-SRAM bank scheduler: rotates three line banks between the pixel
// loader and the CNN window address generator.
// Optional stall counter enabled by defining RSRAM_SCHED_PERF_EN.
module rsram_bank_sched
   import rsram_pkg::*;
#(
   parameter int PIC_W  = 8,
   parameter int PERF_W = 16
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RST,
   input  logic              frame_start,
   input  logic [PIC_W-1:0]  pic_size,
   input  logic              wr_req,
   output logic              wr_grant,
   output logic [1:0]        wr_bank,
   input  logic              wr_done,
   output logic              genaddr_start,
   output logic [1:0]        rd_banksel,
   input  logic              bank_ok,
   output logic              frame_done,
   output logic              busy,
   output logic              err_proto,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   rd_state_e            state, state_nx;
   logic [1:0]           wr_ptr, rd_ptr, rd_nx;
   logic [PIC_W-1:0]     wr_cnt, pair_cnt, n_q;
   logic                 fill_out;
   logic [NUM_BANK-1:0]  is_free, is_full, free_mask;
   logic                 pair_full, last_pair, wr_fin, launch;

   rsram_bank_tracker u_trk (
      .SYS_CLK   (SYS_CLK),
      .SYS_RST   (SYS_RST),
      .fill_en   (wr_grant),
      .fill_idx  (wr_ptr),
      .full_en   (wr_fin),
      .full_idx  (wr_ptr),
      .free_mask (free_mask),
      .is_free   (is_free),
      .is_full   (is_full)
   );

   assign rd_nx      = bank_inc(rd_ptr);
   assign pair_full  = is_full[rd_ptr] & is_full[rd_nx];
   assign last_pair  = (pair_cnt == n_q - PIC_W'(2));
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);
   assign wr_fin     = wr_done & fill_out;
   assign launch     = (state == WAIT) & pair_full;
   // wr_ptr only moves on wr_done, so it names the granted bank until then
   assign wr_bank    = wr_ptr;
   assign wr_grant   = wr_req & ~fill_out & is_free[wr_ptr] & busy & (wr_cnt < n_q);

   // reader FSM state register
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) state <= IDLE;
      else          state <= state_nx;
   end

   // reader FSM next state and bank release on bank_ok
   always_comb begin
      state_nx  = state;
      free_mask = '0;
      case (state)
         IDLE: if (frame_start) state_nx = WAIT;
         WAIT: if (pair_full)   state_nx = RUN;
         RUN: begin
            if (bank_ok) begin
               free_mask[rd_ptr] = 1'b1;
               if (last_pair) begin
                  free_mask[rd_nx] = 1'b1;
                  state_nx         = DONE;
               end else begin
                  state_nx = WAIT;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // pointers, counters, fill tracking and registered reader outputs
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         wr_cnt        <= '0;
         pair_cnt      <= '0;
         n_q           <= '0;
         fill_out      <= 1'b0;
         genaddr_start <= 1'b0;
         rd_banksel    <= '0;
      end else begin
         if (state == IDLE && frame_start)
            n_q <= (pic_size < PIC_W'(2)) ? PIC_W'(2) : pic_size;
         if (wr_grant) fill_out <= 1'b1;
         if (wr_fin) begin
            fill_out <= 1'b0;
            wr_ptr   <= bank_inc(wr_ptr);
            wr_cnt   <= wr_cnt + 1'b1;
         end
         if (state == RUN && bank_ok) begin
            rd_ptr   <= rd_nx;
            pair_cnt <= pair_cnt + 1'b1;
         end
         genaddr_start <= launch;
         if (launch) rd_banksel <= pair_sel(rd_ptr);
         if (state == DONE) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_cnt     <= '0;
            pair_cnt   <= '0;
            fill_out   <= 1'b0;
            rd_banksel <= '0;
         end
      end
   end

   // sticky protocol error
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST)
         err_proto <= 1'b0;
      else if ((frame_start && busy) || (bank_ok && state != RUN) || (wr_done && !fill_out))
         err_proto <= 1'b1;
   end

`ifdef RSRAM_SCHED_PERF_EN
   logic [PERF_W-1:0] stall_q;

   // saturating count of cycles spent waiting for a full pair
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST)
         stall_q <= '0;
      else if (state == IDLE && frame_start)
         stall_q <= '0;
      else if (state == WAIT && stall_q != '1)
         stall_q <= stall_q + 1'b1;
   end

   assign perf_stall_cnt = stall_q;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rsram_bank_sched.sv
// Directed bench for rsram_bank_sched: nominal frame, back-pressure,
// same-cycle wr_done/bank_ok, minimum frame, protocol errors, mid-frame reset.
module tb_rsram_bank_sched;

   localparam int BUD = 200;

   logic        SYS_CLK = 1'b0;
   logic        SYS_RST = 1'b0;
   logic        frame_start = 1'b0;
   logic [7:0]  pic_size = '0;
   logic        wr_req = 1'b0;
   logic        wr_grant;
   logic [1:0]  wr_bank;
   logic        wr_done = 1'b0;
   logic        genaddr_start;
   logic [1:0]  rd_banksel;
   logic        bank_ok = 1'b0;
   logic        frame_done;
   logic        busy;
   logic        err_proto;
   logic [15:0] perf_stall_cnt;

   int errs = 0;
   int checks = 0;

   rsram_bank_sched dut (
      .SYS_CLK        (SYS_CLK),
      .SYS_RST        (SYS_RST),
      .frame_start    (frame_start),
      .pic_size       (pic_size),
      .wr_req         (wr_req),
      .wr_grant       (wr_grant),
      .wr_bank        (wr_bank),
      .wr_done        (wr_done),
      .genaddr_start  (genaddr_start),
      .rd_banksel     (rd_banksel),
      .bank_ok        (bank_ok),
      .frame_done     (frame_done),
      .busy           (busy),
      .err_proto      (err_proto),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // step to just after the next falling edge
   task automatic cyc();
      @(negedge SYS_CLK);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] sz);
      pic_size = sz;
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic req_grant(input logic [1:0] exp_bank);
      int n = 0;
      wr_req = 1'b1;
      #1;
      while (!wr_grant && n < BUD) begin cyc(); n++; end
      chk("grant_timeout", 32'(n < BUD), 32'd1);
      chk("wr_bank", 32'(wr_bank), 32'(exp_bank));
      cyc();
      wr_req = 1'b0;
      chk("grant_one_cycle", 32'(wr_grant), 32'd0);
   endtask

   // wr_done three cycles after the grant cycle
   task automatic complete();
      repeat (2) cyc();
      wr_done = 1'b1;
      cyc();
      wr_done = 1'b0;
   endtask

   task automatic write_bank(input logic [1:0] exp_bank);
      req_grant(exp_bank);
      complete();
   endtask

   task automatic wait_gen(input logic [1:0] exp_sel);
      int n = 0;
      while (!genaddr_start && n < BUD) begin cyc(); n++; end
      chk("gen_timeout", 32'(n < BUD), 32'd1);
      chk("rd_banksel", 32'(rd_banksel), 32'(exp_sel));
   endtask

   task automatic pulse_ok();
      bank_ok = 1'b1;
      cyc();
      bank_ok = 1'b0;
   endtask

   task automatic wait_fd();
      int n = 0;
      while (!frame_done && n < BUD) begin cyc(); n++; end
      chk("fd_timeout", 32'(n < BUD), 32'd1);
      cyc();
      chk("fd_one_cycle", 32'(frame_done), 32'd0);
      chk("busy_after_fd", 32'(busy), 32'd0);
   endtask

   // pic_size=4: banks 0,1,2,0; pairs 00,01,10
   task automatic nominal_frame();
      start_frame(8'd4);
      write_bank(2'd0);
      write_bank(2'd1);
      wait_gen(2'b00);
      write_bank(2'd2);
      pulse_ok();
      req_grant(2'd0);
      wait_gen(2'b01);
      complete();
      pulse_ok();
      wait_gen(2'b10);
      pulse_ok();
      wait_fd();
   endtask

   initial begin
      int k;
      logic any_grant;

      // reset state
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(wr_grant), 32'd0);
      chk("rst_gen", 32'(genaddr_start), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_err", 32'(err_proto), 32'd0);
      chk("rst_sel", 32'(rd_banksel), 32'd0);
      chk("rst_bank", 32'(wr_bank), 32'd0);
      chk("rst_perf", 32'(perf_stall_cnt), 32'd0);
      cyc();
      SYS_RST = 1'b1;
      cyc();

      // nominal
      nominal_frame();
      chk("nominal_err", 32'(err_proto), 32'd0);

      // back-pressure with pic_size=8
      start_frame(8'd8);
      write_bank(2'd0);
      write_bank(2'd1);
      wait_gen(2'b00);
      write_bank(2'd2);
      wr_req = 1'b1;
      any_grant = 1'b0;
      repeat (20) begin
         #1;
         if (wr_grant) any_grant = 1'b1;
         cyc();
      end
      chk("bp_no_grant", 32'(any_grant), 32'd0);
      bank_ok = 1'b1;
      #1;
      chk("bp_not_same_cycle", 32'(wr_grant), 32'd0);
      cyc();
      bank_ok = 1'b0;
      #1;
      chk("bp_grant_next", 32'(wr_grant), 32'd1);
      chk("bp_grant_bank", 32'(wr_bank), 32'd0);
      cyc();
      wr_req = 1'b0;
      wait_gen(2'b01);

      // same-cycle wr_done (bank 0) and bank_ok (bank 1)
      wr_done = 1'b1;
      bank_ok = 1'b1;
      cyc();
      wr_done = 1'b0;
      bank_ok = 1'b0;
      wr_req = 1'b1;
      #1;
      chk("same_free_grant", 32'(wr_grant), 32'd1);
      chk("same_free_bank", 32'(wr_bank), 32'd1);
      cyc();
      wr_req = 1'b0;
      wait_gen(2'b10);
      complete();

      // remaining pairs 2..6 and writes 5..7 of the 8-line frame
      k = 5;
      for (int p = 2; p <= 6; p++) begin
         pulse_ok();
         if (k < 8) req_grant(2'(k % 3));
         if (p < 6) wait_gen(2'((p + 1) % 3));
         if (k < 8) begin complete(); k++; end
      end
      wait_fd();
      chk("bp_err", 32'(err_proto), 32'd0);

      // pic_size=0 behaves as two lines
      start_frame(8'd0);
      write_bank(2'd0);
      write_bank(2'd1);
      wait_gen(2'b00);
      wr_req = 1'b1;
      any_grant = 1'b0;
      repeat (5) begin
         #1;
         if (wr_grant) any_grant = 1'b1;
         cyc();
      end
      wr_req = 1'b0;
      chk("n2_no_third_grant", 32'(any_grant), 32'd0);
      pulse_ok();
      wait_fd();
      chk("n2_err", 32'(err_proto), 32'd0);

      // bank_ok in IDLE, then frame_start while busy
      pulse_ok();
      chk("err_ok_idle", 32'(err_proto), 32'd1);
      start_frame(8'd3);
      pic_size = 8'd5;
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      write_bank(2'd0);
      write_bank(2'd1);
      wait_gen(2'b00);
      write_bank(2'd2);
      pulse_ok();
      wait_gen(2'b01);
      pulse_ok();
      wait_fd();
      chk("err_sticky", 32'(err_proto), 32'd1);

      // reset asserted mid-RUN
      start_frame(8'd4);
      write_bank(2'd0);
      write_bank(2'd1);
      wait_gen(2'b00);
      cyc();
      #2;
      SYS_RST = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sel", 32'(rd_banksel), 32'd0);
      chk("mid_rst_err", 32'(err_proto), 32'd0);
      chk("mid_rst_gen", 32'(genaddr_start), 32'd0);
      chk("mid_rst_fd", 32'(frame_done), 32'd0);
      cyc();
      SYS_RST = 1'b1;
      cyc();
      nominal_frame();
      chk("post_rst_err", 32'(err_proto), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
